nrs_symbol_reader_tx: RTL and testbench

Reads the 16-entry NRS bit buffer that the TX NRS generator fills once per subframe. Converts the bits into 8 QPSK NRS symbols: 4 NRS OFDM symbols × 2 NRS per symbol. Each symbol is tagged with its subcarrier index and OFDM-symbol slot. Symbols are handed to the resource-element mapper over a valid/ready handshake. It is the read side of the generator's `wr_en`/`wr_addr` buffer interface, and it releases the buffer back to the generator when the subframe is drained.

---
 rtl/nrs_symbol_reader_tx_if.sv | 25 ++
 rtl/nrs_symbol_reader_tx.sv | 111 +++++++++++
 tb/tb_nrs_symbol_reader_tx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/nrs_symbol_reader_tx_if.sv
// nrs_symbol_reader_tx_if: buffer read port, config and QPSK symbol handshake of the NRS reader.
interface nrs_symbol_reader_tx_if #(parameter int WIDTH_IQ = 16);
  logic buf_ready;
  logic antenna_port;
  logic [2:0] v_shift;
  logic rd_en;
  logic [3:0] rd_addr;
  logic rd_data;
  logic sym_valid;
  logic sym_ready;
  logic signed [WIDTH_IQ-1:0] sym_i;
  logic signed [WIDTH_IQ-1:0] sym_q;
  logic [3:0] sym_k;
  logic [1:0] sym_l;
  logic sym_last;
  logic buf_release;
  modport master (
    input  buf_ready, antenna_port, v_shift, rd_data, sym_ready,
    output rd_en, rd_addr, sym_valid, sym_i, sym_q, sym_k, sym_l, sym_last, buf_release
  );
  modport slave (
    output buf_ready, antenna_port, v_shift, rd_data, sym_ready,
    input  rd_en, rd_addr, sym_valid, sym_i, sym_q, sym_k, sym_l, sym_last, buf_release
  );
endinterface

// File: rtl/nrs_symbol_reader_tx.sv
// nrs_symbol_reader_tx: drains the 16-bit NRS buffer into 8 tagged QPSK symbols per subframe.
module nrs_symbol_reader_tx #(
  parameter int WIDTH_IQ = 16,
  parameter int AMP      = 23170,
  parameter int DEPTH    = 16
) (
  input logic clk,
  input logic rst,
  nrs_symbol_reader_tx_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, HOLD, DONE} state_t;
  localparam logic signed [WIDTH_IQ-1:0] POS = WIDTH_IQ'(AMP);
  localparam logic signed [WIDTH_IQ-1:0] NEG = -POS;
  localparam logic [2:0] LAST = 3'(DEPTH / 2 - 1);
  state_t state_q;
  logic [2:0] n_q;
  logic ap_q;
  logic [2:0] vs_q;
  logic ibit_q;
  logic rd_en_q;
  logic [3:0] rd_addr_q;
  logic sym_valid_q;
  logic signed [WIDTH_IQ-1:0] sym_i_q;
  logic signed [WIDTH_IQ-1:0] sym_q_q;
  logic [3:0] sym_k_q;
  logic [1:0] sym_l_q;
  logic sym_last_q;
  logic buf_release_q;
  logic [3:0] t_sum;
  logic [3:0] t_d;
  logic [3:0] k_d;
  // v is 3 when the OFDM-symbol parity differs from the antenna port, else 0
  always_comb begin
    t_sum = {1'b0, vs_q} + ((n_q[1] ^ ap_q) ? 4'd3 : 4'd0);
    t_d = (t_sum >= 4'd6) ? t_sum - 4'd6 : t_sum;
    k_d = n_q[0] ? t_d + 4'd6 : t_d;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      n_q           <= '0;
      ap_q          <= 1'b0;
      vs_q          <= '0;
      ibit_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      sym_valid_q   <= 1'b0;
      sym_i_q       <= '0;
      sym_q_q       <= '0;
      sym_k_q       <= '0;
      sym_l_q       <= '0;
      sym_last_q    <= 1'b0;
      buf_release_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.buf_ready) begin
          state_q   <= RD0;
          n_q       <= '0;
          ap_q      <= bus.antenna_port;
          vs_q      <= bus.v_shift;
          rd_en_q   <= 1'b1;
          rd_addr_q <= '0;
        end
        RD0: begin
          state_q   <= RD1;
          rd_addr_q <= {n_q, 1'b1};
        end
        RD1: begin
          state_q <= CAP;
          rd_en_q <= 1'b0;
          ibit_q  <= bus.rd_data;
        end
        CAP: begin
          state_q     <= HOLD;
          sym_valid_q <= 1'b1;
          sym_i_q     <= ibit_q ? NEG : POS;
          sym_q_q     <= bus.rd_data ? NEG : POS;
          sym_k_q     <= k_d;
          sym_l_q     <= n_q[2:1];
          sym_last_q  <= (n_q == LAST);
        end
        HOLD: if (bus.sym_ready) begin
          sym_valid_q <= 1'b0;
          if (n_q == LAST) begin
            state_q       <= DONE;
            buf_release_q <= 1'b1;
          end else begin
            state_q   <= RD0;
            n_q       <= n_q + 3'd1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= {n_q + 3'd1, 1'b0};
          end
        end
        DONE: begin
          state_q       <= IDLE;
          buf_release_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.sym_valid   = sym_valid_q;
  assign bus.sym_i       = sym_i_q;
  assign bus.sym_q       = sym_q_q;
  assign bus.sym_k       = sym_k_q;
  assign bus.sym_l       = sym_l_q;
  assign bus.sym_last    = sym_last_q;
  assign bus.buf_release = buf_release_q;
endmodule

// File: tb/tb_nrs_symbol_reader_tx.sv
// tb_nrs_symbol_reader_tx: table-driven symbol checks plus stall, config-change, reset and back-to-back sequences.
module tb_nrs_symbol_reader_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  nrs_symbol_reader_tx_if #(.WIDTH_IQ(16)) bus ();
  nrs_symbol_reader_tx #(.WIDTH_IQ(16), .AMP(23170), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  logic [15:0] mem;
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  typedef struct packed {
    logic       i_neg;
    logic       q_neg;
    logic [3:0] k;
    logic [1:0] l;
  } exp_t;
  exp_t tbl[24];
  int n_pass = 0;
  int n_chk = 0;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic logic [38:0] cur();
    return {bus.sym_i, bus.sym_q, bus.sym_k, bus.sym_l, bus.sym_last};
  endfunction
  function automatic int out_or();
    return int'(|{bus.rd_en, bus.rd_addr, bus.sym_valid, bus.sym_i, bus.sym_q,
                  bus.sym_k, bus.sym_l, bus.sym_last, bus.buf_release});
  endfunction
  task automatic run_sf(input int base, input logic [15:0] bits, input logic port,
                        input logic [2:0] vs, input int stall, input bit cfgchg,
                        input bit b2b, input int abort_at);
    int idx = 0, rel = 0, rel_t = 0, bad_rd = 0, stall_left = 0, stall_bad = 0;
    bit stalled = 0, exp_rd = 0;
    logic [38:0] snap = '0;
    mem = bits;
    bus.antenna_port = port;
    bus.v_shift = vs;
    bus.sym_ready = 1'b1;
    bus.buf_ready = 1'b1;
    for (int t = 1; t < 400; t++) begin
      @(negedge clk);
      if (!b2b) bus.buf_ready = 1'b0;
      if (t == 1) begin
        check("first_rd_en", int'(bus.rd_en), 1);
        check("first_rd_addr", int'(bus.rd_addr), 0);
      end
      if (t == 4) check("first_valid_latency", int'(bus.sym_valid), 1);
      if (bus.rd_en && bus.sym_valid) bad_rd++;
      if (bus.buf_release) begin
        rel++;
        rel_t = t;
      end
      if (exp_rd) begin
        exp_rd = 0;
        check($sformatf("sym%0d_rd_en", idx), int'(bus.rd_en), 1);
        check($sformatf("sym%0d_rd_addr", idx), int'(bus.rd_addr), 2 * idx);
      end
      if (stall_left > 0) begin
        if (!bus.sym_valid || cur() != snap || bus.rd_en) stall_bad++;
        stall_left--;
        if (stall_left == 0) begin
          bus.sym_ready = 1'b1;
          idx++;
          exp_rd = 1;
        end
      end else if (bus.sym_valid && idx < 8) begin
        if (idx == abort_at) begin
          rst = 1'b0;
          @(negedge clk);
          check("reset_outputs_zero", out_or(), 0);
          rst = 1'b1;
          repeat (6) begin
            @(negedge clk);
            if (bus.buf_release || bus.rd_en) rel++;
          end
          check("no_release_after_reset", rel, 0);
          return;
        end
        check($sformatf("sym%0d_i", idx), int'(bus.sym_i), tbl[base+idx].i_neg ? -23170 : 23170);
        check($sformatf("sym%0d_q", idx), int'(bus.sym_q), tbl[base+idx].q_neg ? -23170 : 23170);
        check($sformatf("sym%0d_k", idx), int'(bus.sym_k), int'(tbl[base+idx].k));
        check($sformatf("sym%0d_l", idx), int'(bus.sym_l), int'(tbl[base+idx].l));
        check($sformatf("sym%0d_last", idx), int'(bus.sym_last), int'(idx == 7));
        if (idx == stall && !stalled) begin
          stalled = 1;
          snap = cur();
          bus.sym_ready = 1'b0;
          stall_left = 10;
        end else begin
          idx++;
          if (idx < 8) exp_rd = 1;
          if (cfgchg && idx == 2) begin
            bus.antenna_port = ~port;
            bus.v_shift = 3'd2;
          end
        end
      end
      if (rel > 0 && t == rel_t + 1) check("idle_after_release_rd_en", int'(bus.rd_en), 0);
      if (rel > 0 && t == rel_t + 2) begin
        if (b2b) check("b2b_rd_en", int'(bus.rd_en), 1);
        else check("no_restart_rd_en", int'(bus.rd_en), 0);
        break;
      end
    end
    check("symbol_count", idx, 8);
    check("release_pulses", rel, 1);
    check("release_cycle", rel_t, (stall >= 0) ? 43 : 33);
    check("rd_en_during_hold", bad_rd, 0);
    if (stall >= 0) check("stall_stable", stall_bad, 0);
  endtask
  initial begin
    int k0[8] = '{0, 6, 3, 9, 0, 6, 3, 9};
    int k1[8] = '{2, 8, 5, 11, 2, 8, 5, 11};
    int k2[8] = '{1, 7, 4, 10, 1, 7, 4, 10};
    logic [15:0] pat = 16'hA5A5;
    for (int i = 0; i < 8; i++) begin
      tbl[i]    = '{1'b0, 1'b0, 4'(k0[i]), 2'(i / 2)};
      tbl[8+i]  = '{pat[2*i], pat[2*i+1], 4'(k1[i]), 2'(i / 2)};
      tbl[16+i] = '{1'b1, 1'b1, 4'(k2[i]), 2'(i / 2)};
    end
    bus.buf_ready = 1'b0;
    bus.sym_ready = 1'b0;
    bus.antenna_port = 1'b0;
    bus.v_shift = 3'd0;
    mem = '0;
    repeat (2) @(negedge clk);
    check("reset_state", out_or(), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_rd_en", int'(bus.rd_en), 0);
    run_sf(0, 16'h0000, 1'b0, 3'd0, -1, 0, 0, -1);
    run_sf(8, 16'hA5A5, 1'b1, 3'd5, -1, 0, 0, -1);
    run_sf(16, 16'hFFFF, 1'b0, 3'd7, -1, 0, 0, -1);
    run_sf(0, 16'h0000, 1'b0, 3'd0, 3, 0, 0, -1);
    run_sf(8, 16'hA5A5, 1'b1, 3'd5, -1, 1, 0, -1);
    run_sf(8, 16'hA5A5, 1'b1, 3'd5, -1, 0, 0, 5);
    run_sf(8, 16'hA5A5, 1'b1, 3'd5, -1, 0, 0, -1);
    run_sf(0, 16'h0000, 1'b0, 3'd0, -1, 0, 1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
